// File: rtl/adjacency_list_map.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adjacency_list_map
//  Description : Graph adjacency store. Edges (src, dst) arrive in any order
//                during LOAD and are appended to a per-node singly linked list
//                in insertion order. In query mode a node index is accepted and
//                its neighbours are streamed back one beat at a time with
//                last/empty markers and the node's out-degree.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                decoding_done         - level, switches LOAD -> query mode
//                edge_valid/edge_ready - edge stream (src_node, dst_node)
//                edge_count, overflow  - stored-edge count, sticky drop flag
//                query_valid/ready     - query stream (query_data)
//                reply_valid/ready     - reply stream (reply_data, reply_last,
//                                        reply_empty, reply_degree)
//  Revision    : 1.0 - initial release
// ============================================================================
module adjacency_list_map #(
    parameter int MAX_NODES      = 1024,
    parameter int MAX_EDGES      = 2048,
    parameter int NODE_WIDTH     = $clog2(MAX_NODES),
    parameter int EDGE_PTR_WIDTH = $clog2(MAX_EDGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      decoding_done,
    output logic                      edge_ready,
    input  logic                      edge_valid,
    input  logic [NODE_WIDTH-1:0]     src_node,
    input  logic [NODE_WIDTH-1:0]     dst_node,
    output logic [EDGE_PTR_WIDTH:0]   edge_count,
    output logic                      overflow,
    output logic                      query_ready,
    input  logic                      query_valid,
    input  logic [NODE_WIDTH-1:0]     query_data,
    input  logic                      reply_ready,
    output logic                      reply_valid,
    output logic [NODE_WIDTH-1:0]     reply_data,
    output logic                      reply_last,
    output logic                      reply_empty,
    output logic [EDGE_PTR_WIDTH:0]   reply_degree
);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_LOAD       = 3'd1,
        S_WAIT_QUERY = 3'd2,
        S_LOOKUP     = 3'd3,
        S_FETCH      = 3'd4,
        S_REPLY      = 3'd5
    } state_t;

    localparam logic [NODE_WIDTH-1:0]   c_LAST_NODE = NODE_WIDTH'(MAX_NODES - 1);
    localparam logic [EDGE_PTR_WIDTH:0] c_EDGE_CAP  = (EDGE_PTR_WIDTH + 1)'(MAX_EDGES);

    // Node table and edge memory
    logic                      r_node_head_valid [MAX_NODES];
    logic [EDGE_PTR_WIDTH-1:0] r_node_head       [MAX_NODES];
    logic [EDGE_PTR_WIDTH-1:0] r_node_tail       [MAX_NODES];
    logic [EDGE_PTR_WIDTH:0]   r_node_degree     [MAX_NODES];
    logic [NODE_WIDTH-1:0]     r_edge_dst        [MAX_EDGES];
    logic [EDGE_PTR_WIDTH-1:0] r_edge_next       [MAX_EDGES];

    // Control / reply registers
    state_t                    r_state_q,        w_state_d;
    logic [NODE_WIDTH-1:0]     r_init_cnt_q,     w_init_cnt_d;
    logic [EDGE_PTR_WIDTH:0]   r_edge_count_q,   w_edge_count_d;
    logic                      r_overflow_q,     w_overflow_d;
    logic [NODE_WIDTH-1:0]     r_query_node_q,   w_query_node_d;
    logic [EDGE_PTR_WIDTH-1:0] r_rd_ptr_q,       w_rd_ptr_d;
    logic [EDGE_PTR_WIDTH-1:0] r_tail_q,         w_tail_d;
    logic                      r_reply_valid_q,  w_reply_valid_d;
    logic [NODE_WIDTH-1:0]     r_reply_data_q,   w_reply_data_d;
    logic                      r_reply_last_q,   w_reply_last_d;
    logic                      r_reply_empty_q,  w_reply_empty_d;
    logic [EDGE_PTR_WIDTH:0]   r_reply_degree_q, w_reply_degree_d;

    logic                      w_edge_accept;
    logic                      w_edge_full;
    logic                      w_edge_write;
    logic [EDGE_PTR_WIDTH-1:0] w_wr_ptr;
    logic                      w_src_head_valid;
    logic [EDGE_PTR_WIDTH-1:0] w_src_tail;
    logic [EDGE_PTR_WIDTH:0]   w_src_degree;

    // Combinational table reads: the write of the previous cycle is already
    // visible, so consecutive edges on one source link without a bypass.
    assign w_src_head_valid = r_node_head_valid[src_node];
    assign w_src_tail       = r_node_tail[src_node];
    assign w_src_degree     = r_node_degree[src_node];

    assign w_edge_accept = edge_valid && (r_state_q == S_LOAD);
    assign w_edge_full   = (r_edge_count_q >= c_EDGE_CAP);
    assign w_edge_write  = w_edge_accept && !w_edge_full && !reset;
    assign w_wr_ptr      = r_edge_count_q[EDGE_PTR_WIDTH-1:0];

    always_comb begin
        w_state_d        = r_state_q;
        w_init_cnt_d     = r_init_cnt_q;
        w_edge_count_d   = r_edge_count_q;
        w_overflow_d     = r_overflow_q;
        w_query_node_d   = r_query_node_q;
        w_rd_ptr_d       = r_rd_ptr_q;
        w_tail_d         = r_tail_q;
        w_reply_valid_d  = r_reply_valid_q;
        w_reply_data_d   = r_reply_data_q;
        w_reply_last_d   = r_reply_last_q;
        w_reply_empty_d  = r_reply_empty_q;
        w_reply_degree_d = r_reply_degree_q;

        case (r_state_q)
            S_INIT: begin
                w_init_cnt_d = r_init_cnt_q + 1'b1;
                if (r_init_cnt_q == c_LAST_NODE) begin
                    w_state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_edge_accept) begin
                    if (w_edge_full) begin
                        w_overflow_d = 1'b1;
                    end else begin
                        w_edge_count_d = r_edge_count_q + 1'b1;
                    end
                end
                if (decoding_done) begin
                    w_state_d = S_WAIT_QUERY;
                end
            end
            S_WAIT_QUERY: begin
                if (query_valid) begin
                    w_query_node_d = query_data;
                    w_state_d      = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!r_node_head_valid[r_query_node_q]) begin
                    w_reply_valid_d  = 1'b1;
                    w_reply_empty_d  = 1'b1;
                    w_reply_last_d   = 1'b1;
                    w_reply_data_d   = '0;
                    w_reply_degree_d = '0;
                    w_state_d        = S_REPLY;
                end else begin
                    w_rd_ptr_d       = r_node_head[r_query_node_q];
                    w_tail_d         = r_node_tail[r_query_node_q];
                    w_reply_degree_d = r_node_degree[r_query_node_q];
                    w_state_d        = S_FETCH;
                end
            end
            S_FETCH: begin
                w_reply_valid_d = 1'b1;
                w_reply_empty_d = 1'b0;
                w_reply_data_d  = r_edge_dst[r_rd_ptr_q];
                w_reply_last_d  = (r_rd_ptr_q == r_tail_q);
                w_state_d       = S_REPLY;
            end
            S_REPLY: begin
                if (reply_ready) begin
                    // Markers drop with valid so they are never seen alone.
                    w_reply_valid_d = 1'b0;
                    w_reply_last_d  = 1'b0;
                    w_reply_empty_d = 1'b0;
                    if (r_reply_last_q) begin
                        w_state_d = S_WAIT_QUERY;
                    end else begin
                        w_rd_ptr_d = r_edge_next[r_rd_ptr_q];
                        w_state_d  = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q        <= S_INIT;
            r_init_cnt_q     <= '0;
            r_edge_count_q   <= '0;
            r_overflow_q     <= 1'b0;
            r_query_node_q   <= '0;
            r_rd_ptr_q       <= '0;
            r_tail_q         <= '0;
            r_reply_valid_q  <= 1'b0;
            r_reply_data_q   <= '0;
            r_reply_last_q   <= 1'b0;
            r_reply_empty_q  <= 1'b0;
            r_reply_degree_q <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_init_cnt_q     <= w_init_cnt_d;
            r_edge_count_q   <= w_edge_count_d;
            r_overflow_q     <= w_overflow_d;
            r_query_node_q   <= w_query_node_d;
            r_rd_ptr_q       <= w_rd_ptr_d;
            r_tail_q         <= w_tail_d;
            r_reply_valid_q  <= w_reply_valid_d;
            r_reply_data_q   <= w_reply_data_d;
            r_reply_last_q   <= w_reply_last_d;
            r_reply_empty_q  <= w_reply_empty_d;
            r_reply_degree_q <= w_reply_degree_d;
        end
    end

    // Memory writes. Only head_valid and degree need clearing; head/tail are
    // rewritten on a node's first edge and next on every append.
    always_ff @(posedge clk) begin
        if (r_state_q == S_INIT && !reset) begin
            r_node_head_valid[r_init_cnt_q] <= 1'b0;
            r_node_degree[r_init_cnt_q]     <= '0;
        end
        if (w_edge_write) begin
            r_edge_dst[w_wr_ptr]  <= dst_node;
            r_edge_next[w_wr_ptr] <= '0;
            if (!w_src_head_valid) begin
                r_node_head_valid[src_node] <= 1'b1;
                r_node_head[src_node]       <= w_wr_ptr;
            end else begin
                // tail always precedes wr_ptr, so this never collides with
                // the clear of edge_next[wr_ptr] above.
                r_edge_next[w_src_tail] <= w_wr_ptr;
            end
            r_node_tail[src_node]   <= w_wr_ptr;
            r_node_degree[src_node] <= w_src_degree + 1'b1;
        end
    end

    assign edge_ready   = (r_state_q == S_LOAD);
    assign query_ready  = (r_state_q == S_WAIT_QUERY);
    assign edge_count   = r_edge_count_q;
    assign overflow     = r_overflow_q;
    assign reply_valid  = r_reply_valid_q;
    assign reply_data   = r_reply_data_q;
    assign reply_last   = r_reply_last_q;
    assign reply_empty  = r_reply_empty_q;
    assign reply_degree = r_reply_degree_q;

endmodule
`default_nettype wire

// File: doc/adjacency_list_map.md
Name: adjacency_list_map

Overview:
- Graph adjacency store for the day-11 path-counting datapath. Accepts (src, dst) edges from the input decoder in any order, not only grouped by source.
- Keeps per-node singly linked edge lists in insertion order.
- Answers neighbour queries over a valid/ready stream with explicit last/empty markers.
- Successor to the grouped-source map:
  - self-initialising node table after reset;
  - interleaved sources;
  - zero-degree replies;
  - edge-overflow detection;
  - degree/edge counters.

Parameters:
- MAX_NODES, 1024, node-table depth; power of two.
- MAX_EDGES, 2048, edge-memory depth; power of two.
- NODE_WIDTH, $clog2(MAX_NODES), node index width.
- EDGE_PTR_WIDTH, $clog2(MAX_EDGES), edge pointer width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- decoding_done  in  1  level; input decoding complete, switches block to query mode.
- edge_ready  out  1  high only in LOAD state.
- edge_valid  in  1  edge strobe; accepted when edge_valid && edge_ready.
- src_node  in  NODE_WIDTH  edge source index.
- dst_node  in  NODE_WIDTH  edge destination index.
- edge_count  out  EDGE_PTR_WIDTH+1  number of edges stored.
- overflow  out  1  sticky; an edge was dropped because memory was full.
- query_ready  out  1  high only in WAIT_QUERY.
- query_valid  in  1  query strobe.
- query_data  in  NODE_WIDTH  node whose neighbours are requested.
- reply_ready  in  1  downstream accept.
- reply_valid  out  1  reply beat valid.
- reply_data  out  NODE_WIDTH  neighbour index (0 on empty reply).
- reply_last  out  1  final beat of the reply.
- reply_empty  out  1  queried node has no out-edges; single beat.
- reply_degree  out  EDGE_PTR_WIDTH+1  out-degree of queried node; valid with every beat.

Behaviour:

Storage:
- Node table entry per node: {head_valid, head, tail, degree}.
- Edge memory entry: {dst, next}.
- Edges are written at wr_ptr = edge_count.

Reset:
- Synchronous; enters INIT and aborts any reply in flight.
- Next cycle: edge_count=0, overflow=0, edge_ready=0, query_ready=0, reply_valid=0, reply_last=0, reply_empty=0, reply_data=0, reply_degree=0.

FSM:
- INIT:
  - Sweep counter clears head_valid and degree for nodes 0..MAX_NODES-1, one per cycle.
  - After node MAX_NODES-1 is cleared, go to LOAD. INIT lasts exactly MAX_NODES cycles.
- LOAD:
  - On an accepted edge with edge_count < MAX_EDGES: edge_mem[wr_ptr] = {dst_node, null}.
  - If !head_valid[src]: head = tail = wr_ptr, head_valid = 1.
  - Else: edge_mem[tail].next = wr_ptr, tail = wr_ptr.
  - degree++, edge_count++.
  - Back-to-back edges on the same src in consecutive cycles must link correctly; table read is combinational or bypassed.
  - Edge with edge_count == MAX_EDGES: dropped, overflow set (sticky until reset), counters unchanged.
  - decoding_done=1 moves to WAIT_QUERY next cycle. An edge presented in that same cycle is still accepted.
- WAIT_QUERY:
  - query_ready=1. On handshake, latch query_data and go to LOOKUP.
- LOOKUP:
  - Read node entry.
  - head_valid=0: go to REPLY with reply_empty=1, reply_last=1, reply_data=0, reply_degree=0.
  - Otherwise go to FETCH with rd_ptr=head.
- FETCH:
  - Read edge_mem[rd_ptr] into reply registers.
  - reply_last = (rd_ptr == tail). Go to REPLY.
- REPLY:
  - reply_valid=1; all reply outputs held stable while reply_ready=0.
  - On handshake with reply_last=1: go to WAIT_QUERY.
  - On handshake otherwise: rd_ptr = next, go to FETCH.

Timing:
- Query handshake at cycle T gives first reply_valid at T+3; empty reply at T+2.
- Subsequent beats occur at most every 2 cycles (FETCH bubble).
- Edges after leaving LOAD are ignored (edge_ready=0). Queries before WAIT_QUERY are not accepted.
- reply_last and reply_empty are asserted only with reply_valid.

Test Plan:
- Reset, then count edge_ready rise -> exactly MAX_NODES cycles after reset deassertion; with MAX_NODES=16, edge_ready=1 on cycle 16.
- Interleaved edges (3->5),(7->1),(3->9),(3->2),(7->4), decoding_done, query 3 -> beats 5,9,2; last only on 2; reply_degree=3 on every beat. Query 7 -> beats 1,4.
- Query node 12 with no edges -> one beat: reply_empty=1, reply_last=1, reply_data=0, reply_degree=0, 2 cycles after handshake.
- MAX_EDGES=4, present 6 edges -> edge_count=4, overflow=1 from the 5th edge on; query shows only the first 4 edges linked.
- Query with 3 neighbours, reply_ready toggling 1,0,0,1,... -> data/last stable while stalled, no beat lost or duplicated. Assert reset during the 2nd beat -> reply_valid=0 next cycle, INIT restarts, and a later query of the same node returns empty.
- Same src on 4 consecutive cycles (src 0 -> 1,2,3,4) -> reply 1,2,3,4 in order, correctly linked.
